// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: conditions the raw lines, frames bytes, and turns make/break
// scan-code sequences into held-key events with typematic repeats filtered.
module ps2_key_decoder #(
   parameter int SYNC_STAGES     = 2,
   parameter int FILTER_LEN      = 4,
   parameter int TIMEOUT_CYCLES  = 50000,
   parameter bit SUPPRESS_REPEAT = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] code,
   output logic       pressed,
   output logic       extended,
   output logic       key_valid,
   output logic       frame_err,
   output logic       any_held
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [SYNC_STAGES-1:0] clk_sync, data_sync;
   logic                   clk_s, data_s;
   logic                   filt_clk;
   logic [FW-1:0]          filt_cnt;
   logic                   sample_edge;

   state_t       state, state_n;
   logic [7:0]   shift, shift_n;
   logic [2:0]   bit_cnt, bit_cnt_n;
   logic         par_ok, par_ok_n;
   logic [TW-1:0] to_cnt;
   logic         timeout, rx_done, rx_bad;
   logic         rx_valid;
   logic [7:0]   rx_byte;

   logic [511:0] held, held_n;
   logic         ext_f, brk_f, ext_n, brk_n;
   logic         ev, ev_pressed;
   logic [8:0]   key;

   // Idle PS/2 lines are high, so the synchronisers reset to 1 to avoid a false start edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync  <= '1;
         data_sync <= '1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      end
   end

   assign clk_s  = clk_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt_clk <= 1'b1;
         filt_cnt <= '0;
      end else if (clk_s == filt_clk) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
         filt_clk <= clk_s;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + FW'(1);
      end
   end

   assign sample_edge = filt_clk && !clk_s && (filt_cnt == FW'(FILTER_LEN - 1));
   assign timeout     = (state != IDLE) && !sample_edge && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_n   = state;
      shift_n   = shift;
      bit_cnt_n = bit_cnt;
      par_ok_n  = par_ok;
      rx_done   = 1'b0;
      rx_bad    = 1'b0;
      if (timeout) begin
         state_n = IDLE;
      end else if (sample_edge) begin
         case (state)
            IDLE: begin
               if (!data_s) begin
                  state_n   = DATA;
                  bit_cnt_n = '0;
               end
            end
            DATA: begin
               shift_n   = {data_s, shift[7:1]};
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_n = PARITY;
            end
            PARITY: begin
               par_ok_n = ^{shift, data_s};
               state_n  = STOP;
            end
            default: begin
               state_n = IDLE;
               if (par_ok && data_s) rx_done = 1'b1;
               else                  rx_bad  = 1'b1;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         shift     <= '0;
         bit_cnt   <= '0;
         par_ok    <= 1'b0;
         to_cnt    <= '0;
         rx_valid  <= 1'b0;
         rx_byte   <= '0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         shift     <= shift_n;
         bit_cnt   <= bit_cnt_n;
         par_ok    <= par_ok_n;
         to_cnt    <= (state == IDLE || sample_edge) ? '0 : to_cnt + TW'(1);
         rx_valid  <= rx_done;
         frame_err <= rx_bad | timeout;
         if (rx_done) rx_byte <= shift;
      end
   end

   always_comb begin
      held_n     = held;
      ext_n      = ext_f;
      brk_n      = brk_f;
      ev         = 1'b0;
      ev_pressed = 1'b0;
      key        = {ext_f, rx_byte};
      if (frame_err) begin
         ext_n = 1'b0;
         brk_n = 1'b0;
      end else if (rx_valid) begin
         case (rx_byte)
            8'hE0: ext_n = 1'b1;
            8'hF0: brk_n = 1'b1;
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF, 8'hE1: begin
               ext_n = 1'b0;
               brk_n = 1'b0;
            end
            default: begin
               ext_n = 1'b0;
               brk_n = 1'b0;
               if (brk_f) begin
                  held_n[key] = 1'b0;
                  ev          = 1'b1;
               end else if (!(SUPPRESS_REPEAT && held[key])) begin
                  held_n[key] = 1'b1;
                  ev          = 1'b1;
                  ev_pressed  = 1'b1;
               end
            end
         endcase
      end
   end

   // NOTE: the held map is plain flops, not RAM, so it clears on the async reset like any other state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         held      <= '0;
         ext_f     <= 1'b0;
         brk_f     <= 1'b0;
         key_valid <= 1'b0;
         code      <= '0;
         pressed   <= 1'b0;
         extended  <= 1'b0;
         any_held  <= 1'b0;
      end else begin
         held      <= held_n;
         ext_f     <= ext_n;
         brk_f     <= brk_n;
         key_valid <= ev;
         if (ev) begin
            code     <= rx_byte;
            pressed  <= ev_pressed;
            extended <= ext_f;
            any_held <= |held_n;
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a table of frames with expected events, plus
// hand-written timeout and mid-frame reset sequences. A second instance runs without repeat filtering.
module tb_ps2_key_decoder;

   localparam int TO   = 1000;
   localparam int HALF = 12;

   logic       clk = 1'b0;
   logic       reset, ps2_clk, ps2_data;
   logic [7:0] code, code0;
   logic       pressed, extended, key_valid, frame_err, any_held;
   logic       pressed0, extended0, key_valid0, frame_err0, any_held0;

   int chk_cnt = 0, pass_cnt = 0;
   int kv_cnt = 0, fe_cnt = 0, kv0_cnt = 0, both_cnt = 0;

   typedef struct {
      logic [7:0] b;
      logic       pf;
      logic       st;
      int         kv;
      int         err;
      int         kv0;
      logic [7:0] code;
      logic       pr;
      logic       ex;
      logic       held;
   } vec_t;

   vec_t vecs[$];

   ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .SUPPRESS_REPEAT(1'b1)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .code(code), .pressed(pressed), .extended(extended),
      .key_valid(key_valid), .frame_err(frame_err), .any_held(any_held)
   );

   ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .SUPPRESS_REPEAT(1'b0)) dut0 (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .code(code0), .pressed(pressed0), .extended(extended0),
      .key_valid(key_valid0), .frame_err(frame_err0), .any_held(any_held0)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (key_valid)              kv_cnt++;
      if (frame_err)              fe_cnt++;
      if (key_valid && frame_err) both_cnt++;
      if (key_valid0)             kv0_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sends the first nbits bits of a frame (start, 8 data LSB first, parity, stop).
   task automatic send_frame(input logic [7:0] b, input logic pf, input logic st, input int nbits);
      logic [10:0] f;
      f = {st, (~^b) ^ pf, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         wait_clks(HALF);
         ps2_clk = 1'b0;
         wait_clks(HALF);
         ps2_clk = 1'b1;
      end
      wait_clks(HALF);
      ps2_data = 1'b1;
   endtask

   task automatic add(input logic [7:0] b, input logic pf, input logic st, input int kv,
                      input int err, input int kv0, input logic [7:0] c, input logic pr,
                      input logic ex, input logic hl);
      vec_t v;
      v = '{b: b, pf: pf, st: st, kv: kv, err: err, kv0: kv0, code: c, pr: pr, ex: ex, held: hl};
      vecs.push_back(v);
   endtask

   task automatic frame_expect(input string name, input logic [7:0] b, input int kv, input int err,
                               input logic [7:0] c, input logic pr, input logic ex, input logic hl);
      int kv_b, fe_b;
      kv_b = kv_cnt;
      fe_b = fe_cnt;
      send_frame(b, 1'b0, 1'b1, 11);
      wait_clks(30);
      check({name, " kv"}, kv_cnt - kv_b, kv);
      check({name, " err"}, fe_cnt - fe_b, err);
      check({name, " outs"}, {code, pressed, extended, any_held}, {c, pr, ex, hl});
   endtask

   initial begin
      int kv_b, fe_b, kv0_b;
      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_clks(5);
      check("reset_state", {code, pressed, extended, key_valid, frame_err, any_held}, 32'd0);
      reset = 1'b0;
      wait_clks(10);
      check("post_reset", {code, pressed, extended, key_valid, frame_err, any_held}, 32'd0);

      //   b     pf st kv er kv0 code  pr ex held
      add(8'h15, 0, 1, 1, 0, 1, 8'h15, 1, 0, 1);
      add(8'hF0, 0, 1, 0, 0, 0, 8'h15, 1, 0, 1);
      add(8'h15, 0, 1, 1, 0, 1, 8'h15, 0, 0, 0);
      add(8'hE0, 0, 1, 0, 0, 0, 8'h15, 0, 0, 0);
      add(8'h75, 0, 1, 1, 0, 1, 8'h75, 1, 1, 1);
      add(8'hE0, 0, 1, 0, 0, 0, 8'h75, 1, 1, 1);
      add(8'hF0, 0, 1, 0, 0, 0, 8'h75, 1, 1, 1);
      add(8'h75, 0, 1, 1, 0, 1, 8'h75, 0, 1, 0);
      add(8'h15, 1, 1, 0, 1, 0, 8'h75, 0, 1, 0);
      add(8'h1D, 0, 1, 1, 0, 1, 8'h1D, 1, 0, 1);
      add(8'h1D, 0, 1, 0, 0, 1, 8'h1D, 1, 0, 1);
      add(8'h1D, 0, 1, 0, 0, 1, 8'h1D, 1, 0, 1);
      add(8'hF0, 0, 1, 0, 0, 0, 8'h1D, 1, 0, 1);
      add(8'h1D, 0, 1, 1, 0, 1, 8'h1D, 0, 0, 0);
      add(8'hE0, 0, 1, 0, 0, 0, 8'h1D, 0, 0, 0);
      add(8'hAA, 0, 1, 0, 0, 0, 8'h1D, 0, 0, 0);
      add(8'h15, 0, 1, 1, 0, 1, 8'h15, 1, 0, 1);
      add(8'hE0, 0, 1, 0, 0, 0, 8'h15, 1, 0, 1);
      add(8'h15, 0, 0, 0, 1, 0, 8'h15, 1, 0, 1);
      add(8'hF0, 0, 1, 0, 0, 0, 8'h15, 1, 0, 1);
      add(8'h15, 0, 1, 1, 0, 1, 8'h15, 0, 0, 0);
      add(8'hE0, 0, 1, 0, 0, 0, 8'h15, 0, 0, 0);
      add(8'h75, 0, 1, 1, 0, 1, 8'h75, 1, 1, 1);
      add(8'h15, 0, 1, 1, 0, 1, 8'h15, 1, 0, 1);
      add(8'hE0, 0, 1, 0, 0, 0, 8'h15, 1, 0, 1);
      add(8'h15, 0, 1, 1, 0, 1, 8'h15, 1, 1, 1);
      add(8'hF0, 0, 1, 0, 0, 0, 8'h15, 1, 1, 1);
      add(8'h15, 0, 1, 1, 0, 1, 8'h15, 0, 0, 1);
      add(8'hE0, 0, 1, 0, 0, 0, 8'h15, 0, 0, 1);
      add(8'hF0, 0, 1, 0, 0, 0, 8'h15, 0, 0, 1);
      add(8'h15, 0, 1, 1, 0, 1, 8'h15, 0, 1, 1);
      add(8'hE0, 0, 1, 0, 0, 0, 8'h15, 0, 1, 1);
      add(8'hF0, 0, 1, 0, 0, 0, 8'h15, 0, 1, 1);
      add(8'h75, 0, 1, 1, 0, 1, 8'h75, 0, 1, 0);
      add(8'hF0, 0, 1, 0, 0, 0, 8'h75, 0, 1, 0);
      add(8'h33, 0, 1, 1, 0, 1, 8'h33, 0, 0, 0);

      foreach (vecs[i]) begin
         kv_b  = kv_cnt;
         fe_b  = fe_cnt;
         kv0_b = kv0_cnt;
         send_frame(vecs[i].b, vecs[i].pf, vecs[i].st, 11);
         wait_clks(30);
         check($sformatf("v%0d key_valid count", i), kv_cnt - kv_b, vecs[i].kv);
         check($sformatf("v%0d frame_err count", i), fe_cnt - fe_b, vecs[i].err);
         check($sformatf("v%0d no-suppress count", i), kv0_cnt - kv0_b, vecs[i].kv0);
         check($sformatf("v%0d code", i), code, vecs[i].code);
         check($sformatf("v%0d pressed", i), pressed, vecs[i].pr);
         check($sformatf("v%0d extended", i), extended, vecs[i].ex);
         check($sformatf("v%0d any_held", i), any_held, vecs[i].held);
      end

      // Timeout: E0 prefix, then a frame abandoned after start + 4 data bits.
      send_frame(8'hE0, 1'b0, 1'b1, 11);
      wait_clks(30);
      kv_b = kv_cnt;
      fe_b = fe_cnt;
      send_frame(8'h24, 1'b0, 1'b1, 5);
      wait_clks(TO - 100);
      check("timeout early", fe_cnt - fe_b, 0);
      wait_clks(200);
      check("timeout err", fe_cnt - fe_b, 1);
      check("timeout no key", kv_cnt - kv_b, 0);
      frame_expect("after timeout 24", 8'h24, 1, 0, 8'h24, 1'b1, 1'b0, 1'b1);

      // Reset asserted mid-frame clears outputs asynchronously and discards the partial byte.
      send_frame(8'h15, 1'b0, 1'b1, 4);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("async reset outs", {code, pressed, extended, key_valid, frame_err, any_held}, 32'd0);
      wait_clks(3);
      reset = 1'b0;
      wait_clks(10);
      frame_expect("after reset 15", 8'h15, 1, 0, 8'h15, 1'b1, 1'b0, 1'b1);
      frame_expect("after reset F0", 8'hF0, 0, 0, 8'h15, 1'b1, 1'b0, 1'b1);
      frame_expect("after reset brk 15", 8'h15, 1, 0, 8'h15, 1'b0, 1'b0, 1'b0);

      check("strobe overlap", both_cnt, 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
